// File: rtl/inst_mem.sv
// Instruction memory with a power-up clear sweep, a registered fetch port and a program-load write port.
// Define INST_MEM_PARITY_EN to store an even-parity bit per word and report parity_err on fetch.
module inst_mem #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    output logic              ready,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
`ifdef INST_MEM_PARITY_EN
    ,
    input  logic              ld_par_flip,
    output logic              parity_err
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef INST_MEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] counter;
    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] ld_word;
    logic [WORD_W-1:0] rd_word;

`ifdef INST_MEM_PARITY_EN
    // Stored bit makes the whole word even; a flipped load deliberately corrupts it.
    assign ld_word = {(^ld_data) ^ ld_par_flip, ld_data};
`else
    assign ld_word = ld_data;
`endif

    assign rd_word = mem[addr];

    // NOTE: the array has no reset branch so it maps onto RAM; the CLEAR sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[counter] <= '0;
            end else if (ld_en) begin
                mem[ld_addr] <= ld_word;
            end
        end
    end

    // NOTE: non-blocking reads of mem here see the pre-edge word, which gives read-before-write on a same-address load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            counter    <= '0;
            ready      <= 1'b0;
            inst       <= '0;
            inst_valid <= 1'b0;
`ifdef INST_MEM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            case (state)
                CLEAR: begin
                    counter    <= counter + ADDR_W'(1);
                    inst       <= '0;
                    inst_valid <= 1'b0;
`ifdef INST_MEM_PARITY_EN
                    parity_err <= 1'b0;
`endif
                    if (counter == LAST) begin
                        state <= READY;
                        ready <= 1'b1;
                    end
                end
                READY: begin
                    if (ce) begin
                        inst       <= rd_word[DATA_W-1:0];
                        inst_valid <= 1'b1;
`ifdef INST_MEM_PARITY_EN
                        parity_err <= ^rd_word;
`endif
                    end else begin
                        inst       <= '0;
                        inst_valid <= 1'b0;
`ifdef INST_MEM_PARITY_EN
                        parity_err <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= CLEAR;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem.sv
// Self-checking bench for inst_mem: a per-cycle reference model plus directed literal checks and random traffic.
module tb_inst_mem;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] inst;
    logic          inst_valid;
    logic          ready;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
`ifdef INST_MEM_PARITY_EN
    logic          ld_par_flip = 1'b0;
    logic          parity_err;
`endif

    int checks = 0;
    int errors = 0;

    inst_mem #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .addr       (addr),
        .inst       (inst),
        .inst_valid (inst_valid),
        .ready      (ready),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data)
`ifdef INST_MEM_PARITY_EN
        ,
        .ld_par_flip(ld_par_flip),
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as an array, readiness as edges elapsed since the last reset.
    logic [DW-1:0] mdl [DEPTH];
    logic          mdl_bad [DEPTH];
    int            since_rst = 0;
    bit            armed = 1'b0;
    logic [DW-1:0] exp_inst;
    logic          exp_valid, exp_ready, exp_perr;

    always @(posedge clk) begin
        if (rst) begin
            armed = 1'b1;
            since_rst = 0;
            exp_inst = '0; exp_valid = 1'b0; exp_ready = 1'b0; exp_perr = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mdl[i] = '0;
                mdl_bad[i] = 1'b0;
            end
        end else if (since_rst < DEPTH) begin
            since_rst++;
            exp_inst = '0; exp_valid = 1'b0; exp_perr = 1'b0;
            exp_ready = (since_rst == DEPTH);
        end else begin
            exp_valid = ce;
            exp_inst  = ce ? mdl[addr] : '0;
            exp_perr  = ce ? mdl_bad[addr] : 1'b0;
            if (ld_en) begin
                mdl[ld_addr] = ld_data;
`ifdef INST_MEM_PARITY_EN
                mdl_bad[ld_addr] = ld_par_flip;
`endif
            end
        end
        #1;
        if (armed) begin
            check("cyc_ready", DW'(ready), DW'(exp_ready));
            check("cyc_valid", DW'(inst_valid), DW'(exp_valid));
            check("cyc_inst", inst, exp_inst);
`ifdef INST_MEM_PARITY_EN
            check("cyc_perr", DW'(parity_err), DW'(exp_perr));
`endif
        end
    end

    // Apply one cycle of inputs at a falling edge and return at the next falling edge.
    task automatic drive(input logic r, input logic c, input logic [AW-1:0] a,
                         input logic l, input logic [AW-1:0] la, input logic [DW-1:0] ld);
        rst = r; ce = c; addr = a; ld_en = l; ld_addr = la; ld_data = ld;
        @(negedge clk);
    endtask

    task automatic rand_cycle(input logic r);
        drive(r, 1'($urandom), AW'($urandom), 1'($urandom), AW'($urandom), $urandom);
    endtask

    // Counts edges from reset release until ready rises; bounded so a stuck controller still finishes.
    task automatic wait_ready(input string name, input bit noisy);
        int n = 0;
        while (n < 200) begin
            if (noisy) rand_cycle(1'b0);
            else drive(1'b0, 1'b0, '0, 1'b0, '0, '0);
            n++;
            if (ready) break;
        end
        check(name, DW'(n), DW'(64));
    endtask

    initial begin
        @(negedge clk);
        drive(1'b1, 1'b0, '0, 1'b0, '0, '0);
        check("rst_ready", DW'(ready), '0);
        check("rst_valid", DW'(inst_valid), '0);
        check("rst_inst", inst, '0);

        wait_ready("clear_len", 1'b0);

        // Single load and fetch, then an idle cycle.
        drive(1'b0, 1'b0, '0, 1'b1, 6'd5, 32'h2001_0005);
        drive(1'b0, 1'b1, 6'd5, 1'b0, '0, '0);
        check("fetch5", inst, 32'h2001_0005);
        check("fetch5_v", DW'(inst_valid), DW'(1));
        drive(1'b0, 1'b0, 6'd5, 1'b0, '0, '0);
        check("idle_inst", inst, '0);
        check("idle_v", DW'(inst_valid), '0);

        // Back-to-back sweep with address wrap 63 -> 0.
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b0, '0, 1'b1, AW'(i), DW'(i));
        for (int i = 0; i <= DEPTH; i++) begin
            drive(1'b0, 1'b1, AW'(i), 1'b0, '0, '0);
            check("sweep", inst, DW'(i % DEPTH));
            check("sweep_v", DW'(inst_valid), DW'(1));
        end

        // Same-address fetch and load: old word first, new word next.
        drive(1'b0, 1'b0, '0, 1'b1, 6'd9, 32'hAAAA_0000);
        drive(1'b0, 1'b1, 6'd9, 1'b1, 6'd9, 32'h1234_5678);
        check("rbw_old", inst, 32'hAAAA_0000);
        drive(1'b0, 1'b1, 6'd9, 1'b0, '0, '0);
        check("rbw_new", inst, 32'h1234_5678);

        // Different-address fetch and load at the same edge.
        drive(1'b0, 1'b1, 6'd9, 1'b1, 6'd10, 32'hCAFE_F00D);
        check("diff_fetch", inst, 32'h1234_5678);
        drive(1'b0, 1'b1, 6'd10, 1'b0, '0, '0);
        check("diff_load", inst, 32'hCAFE_F00D);

`ifdef INST_MEM_PARITY_EN
        ld_par_flip = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b1, 6'd3, 32'h0000_0007);
        ld_par_flip = 1'b0;
        drive(1'b0, 1'b1, 6'd3, 1'b0, '0, '0);
        check("par_bad", DW'(parity_err), DW'(1));
        drive(1'b0, 1'b0, '0, 1'b1, 6'd3, 32'h0000_0007);
        drive(1'b0, 1'b1, 6'd3, 1'b0, '0, '0);
        check("par_good", DW'(parity_err), '0);
`endif

        // Random traffic; the model checks every cycle.
        for (int i = 0; i < 400; i++) rand_cycle(1'b0);

        // Reset after loading: full clear with inputs toggling, then old contents read 0.
        drive(1'b1, 1'b1, 6'd5, 1'b1, 6'd5, 32'hFFFF_FFFF);
        check("rst2_ready", DW'(ready), '0);
        wait_ready("clear_len2", 1'b1);
        drive(1'b0, 1'b1, 6'd5, 1'b0, '0, '0);
        check("cleared5", inst, '0);
        drive(1'b0, 1'b1, 6'd9, 1'b0, '0, '0);
        check("cleared9", inst, '0);
        drive(1'b0, 1'b1, 6'd10, 1'b0, '0, '0);
        check("cleared10", inst, '0);

        // Reset mid-clear restarts the sweep.
        drive(1'b1, 1'b0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 20; i++) rand_cycle(1'b0);
        drive(1'b1, 1'b0, '0, 1'b0, '0, '0);
        wait_ready("clear_len3", 1'b1);

        for (int i = 0; i < 300; i++) rand_cycle(1'b0);
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_mem.md
INST_MEM -- requirements
Module: inst_mem

Interface
REQ-001 Parameter ADDR_W, default 6, SHALL set address width; depth DEPTH = 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 32, SHALL set instruction word width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ce  input  1  fetch enable from the PC stage; 1 = fetch requested this cycle.
REQ-006 addr  input  ADDR_W  fetch address (word index).
REQ-007 inst  output  DATA_W  fetched instruction, registered.
REQ-008 inst_valid  output  1  1 = inst holds data for the fetch sampled at the previous edge.
REQ-009 ready  output  1  1 = memory initialised and serving fetches/loads.
REQ-010 ld_en  input  1  program-load write strobe.
REQ-011 ld_addr  input  ADDR_W  load word index.
REQ-012 ld_data  input  DATA_W  load word.

Function
REQ-013 Storage SHALL be DEPTH x DATA_W words; addr and ld_addr SHALL index modulo DEPTH, with no out-of-range condition.
REQ-014 The controller SHALL have exactly two states, CLEAR and READY; reset SHALL enter CLEAR with clear counter = 0.
REQ-015 In CLEAR, each edge SHALL write 0 to mem[counter] and increment counter; at counter = DEPTH-1, the next state SHALL be READY (CLEAR lasts exactly DEPTH cycles).
REQ-016 ready SHALL be 1 only in READY, as a registered output.
REQ-017 In CLEAR, ce, ld_en and addr SHALL be ignored; inst SHALL be 0 and inst_valid SHALL be 0.
REQ-018 In READY with ce=1 at edge N, inst SHALL be mem[addr] and inst_valid SHALL be 1 from edge N until edge N+1 (1-cycle latency; one fetch per cycle, back-to-back allowed).
REQ-019 In READY with ce=0 at edge N, inst SHALL be 0 (NOP) and inst_valid SHALL be 0 after edge N.
REQ-020 In READY with ld_en=1 at an edge, mem[ld_addr] SHALL be updated with ld_data.
REQ-021 Fetch and load to the same address at the same edge SHALL return the old word (read-before-write); the new word SHALL be visible from the next fetch.
REQ-022 Fetch and load to different addresses at the same edge SHALL both complete with no interaction.
REQ-023 Zeroed words SHALL decode as NOP downstream; no other default content is defined.

Reset
REQ-024 rst=1 at an edge SHALL set inst=0, inst_valid=0, ready=0, state=CLEAR, counter=0; this SHALL take priority over ce and ld_en.
REQ-025 Reset asserted mid-CLEAR or mid-READY SHALL restart the full DEPTH-cycle clear, so that all prior contents read as 0 afterward.

Configuration
REQ-026 Macro INST_MEM_PARITY_EN defined: each word SHALL store one extra even-parity bit computed from ld_data on load (clear writes parity 0).
REQ-027 With INST_MEM_PARITY_EN, ports SHALL be added: ld_par_flip input 1 (inverts the stored parity bit on that load) and parity_err output 1 (registered alongside inst, 1 when the fetched word's parity mismatches, 0 whenever inst_valid=0, reset 0).
REQ-028 Without INST_MEM_PARITY_EN: no parity storage, no ld_par_flip or parity_err ports, and all other behaviour identical.

Verification
REQ-029 Release rst, hold ce=0 -> ready=0 for 64 cycles then 1; inst=0 and inst_valid=0 throughout.
REQ-030 After ready: load mem[5]=0x20010005, then ce=1, addr=5 -> next cycle inst=0x20010005, inst_valid=1; ce=0 the following cycle -> inst=0, inst_valid=0.
REQ-031 Fetch addr=0..63 back-to-back after loading mem[i]=i -> inst=i every cycle, inst_valid held at 1, and address 63 followed by 0 with no gap.
REQ-032 mem[9]=0xAAAA0000; same edge ld_en, ld_addr=9, ld_data=0x12345678 and ce=1, addr=9 -> inst=0xAAAA0000; refetch -> 0x12345678.
REQ-033 Assert rst for 1 cycle after loading -> ready=0 for 64 cycles, then fetch of any previously loaded address returns 0.
REQ-034 With INST_MEM_PARITY_EN: load mem[3] with ld_par_flip=1, fetch addr=3 -> parity_err=1; reload mem[3] with ld_par_flip=0 and fetch -> parity_err=0.
